// File: rtl/decode_pkg.sv
// Shared RV64IM decode constants: opcodes, funct3/funct7 codes and the
// immediate-format enumeration used by the decode stage.
package decode_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct7 groups
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // M-extension funct3
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Load/store size funct3
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  // Immediate format; FMT_SYS is I-immediate without a destination,
  // FMT_SH/FMT_SHW carry only the 6-/5-bit shift amount.
  typedef enum logic [3:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_SHW, FMT_SYS
  } fmt_e;

  // True for formats that write rd
  function automatic logic fmt_has_rd(input fmt_e f);
    logic r;
    case (f)
      FMT_NONE, FMT_S, FMT_B, FMT_SYS: r = 1'b0;
      default:                         r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32 x 64 integer register file: two combinational read ports with
// write-through bypass, one write port, asynchronous clear. x0 reads zero.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];

  // Write port; reset clears everything and wins over a same-cycle write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: x0 is hard zero; a pending write to the same register is
  // forwarded, except while reset is held (that write will be discarded)
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic bypass;
    assign bypass = reset && wr_en && (wr_addr != '0) && (wr_addr == rd_addr[gi]);
    assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                         bypass              ? wr_data : regs[rd_addr[gi]];
  end

endmodule

// File: rtl/decode.sv
// RV64IM decode stage: purely combinational decode of the stage-1 word into
// operands, immediate, destination and an ASCII mnemonic; owns the regfile.
module decode
  import decode_pkg::*;
#(
  parameter int BUS_DATA_WIDTH         = 64,
  parameter int REGISTER_WIDTH         = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 12
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [31:0]                           stage1_instruction_bits,
  input  logic [BUS_DATA_WIDTH-1:0]             stage1_pc,
  input  logic                                  wb_en,
  input  logic [REGISTER_WIDTH-1:0]             wb_dest,
  input  logic [BUS_DATA_WIDTH-1:0]             wb_data,
  output logic [BUS_DATA_WIDTH-1:0]             nstage2_valA,
  output logic [BUS_DATA_WIDTH-1:0]             nstage2_valB,
  output logic [BUS_DATA_WIDTH-1:0]             nstage2_immediate,
  output logic [BUS_DATA_WIDTH-1:0]             nstage2_pc,
  output logic [REGISTER_WIDTH-1:0]             nstage2_dest,
  output logic [INSTRUCTION_NAME_WIDTH*8:0]     nstage2_op
);

  localparam int OP_W = INSTRUCTION_NAME_WIDTH * 8 + 1;

  typedef struct packed {
    fmt_e            fmt;
    logic [OP_W-1:0] name;
  } dec_t;

  // Mnemonic and format lookup; an empty name means the encoding is undefined
  function automatic dec_t decode_inst(input logic [31:0] inst);
    dec_t            d;
    logic [OP_W-1:0] nm;
    fmt_e            f;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    nm  = '0;
    f   = FMT_NONE;
    case (opc)
      OPC_LUI:   begin f = FMT_U; nm = OP_W'("lui");   end
      OPC_AUIPC: begin f = FMT_U; nm = OP_W'("auipc"); end
      OPC_JAL:   begin f = FMT_J; nm = OP_W'("jal");   end
      OPC_JALR:  begin f = FMT_I; if (f3 == 3'd0) nm = OP_W'("jalr"); end
      OPC_BRANCH: begin
        f = FMT_B;
        case (f3)
          F3_BEQ:  nm = OP_W'("beq");
          F3_BNE:  nm = OP_W'("bne");
          F3_BLT:  nm = OP_W'("blt");
          F3_BGE:  nm = OP_W'("bge");
          F3_BLTU: nm = OP_W'("bltu");
          F3_BGEU: nm = OP_W'("bgeu");
          default: ;
        endcase
      end
      OPC_LOAD: begin
        f = FMT_I;
        case (f3)
          F3_B:  nm = OP_W'("lb");
          F3_H:  nm = OP_W'("lh");
          F3_W:  nm = OP_W'("lw");
          F3_D:  nm = OP_W'("ld");
          F3_BU: nm = OP_W'("lbu");
          F3_HU: nm = OP_W'("lhu");
          F3_WU: nm = OP_W'("lwu");
          default: ;
        endcase
      end
      OPC_STORE: begin
        f = FMT_S;
        case (f3)
          F3_B: nm = OP_W'("sb");
          F3_H: nm = OP_W'("sh");
          F3_W: nm = OP_W'("sw");
          F3_D: nm = OP_W'("sd");
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        f = FMT_I;
        case (f3)
          F3_ADD:  nm = OP_W'("addi");
          F3_SLT:  nm = OP_W'("slti");
          F3_SLTU: nm = OP_W'("sltiu");
          F3_XOR:  nm = OP_W'("xori");
          F3_OR:   nm = OP_W'("ori");
          F3_AND:  nm = OP_W'("andi");
          F3_SLL: begin
            f = FMT_SH;
            if (inst[31:26] == 6'b000000) nm = OP_W'("slli");
          end
          default: begin
            f = FMT_SH;
            if (inst[31:26] == 6'b000000)      nm = OP_W'("srli");
            else if (inst[31:26] == 6'b010000) nm = OP_W'("srai");
          end
        endcase
      end
      OPC_OP_IMM32: begin
        f = FMT_SHW;
        case (f3)
          F3_ADD: begin f = FMT_I; nm = OP_W'("addiw"); end
          F3_SLL: if (f7 == F7_BASE) nm = OP_W'("slliw");
          F3_SR: begin
            if (f7 == F7_BASE)     nm = OP_W'("srliw");
            else if (f7 == F7_ALT) nm = OP_W'("sraiw");
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        f = FMT_R;
        case ({f7, f3})
          {F7_BASE, F3_ADD}:      nm = OP_W'("add");
          {F7_ALT,  F3_ADD}:      nm = OP_W'("sub");
          {F7_BASE, F3_SLL}:      nm = OP_W'("sll");
          {F7_BASE, F3_SLT}:      nm = OP_W'("slt");
          {F7_BASE, F3_SLTU}:     nm = OP_W'("sltu");
          {F7_BASE, F3_XOR}:      nm = OP_W'("xor");
          {F7_BASE, F3_SR}:       nm = OP_W'("srl");
          {F7_ALT,  F3_SR}:       nm = OP_W'("sra");
          {F7_BASE, F3_OR}:       nm = OP_W'("or");
          {F7_BASE, F3_AND}:      nm = OP_W'("and");
          {F7_MULDIV, F3_MUL}:    nm = OP_W'("mul");
          {F7_MULDIV, F3_MULH}:   nm = OP_W'("mulh");
          {F7_MULDIV, F3_MULHSU}: nm = OP_W'("mulhsu");
          {F7_MULDIV, F3_MULHU}:  nm = OP_W'("mulhu");
          {F7_MULDIV, F3_DIV}:    nm = OP_W'("div");
          {F7_MULDIV, F3_DIVU}:   nm = OP_W'("divu");
          {F7_MULDIV, F3_REM}:    nm = OP_W'("rem");
          {F7_MULDIV, F3_REMU}:   nm = OP_W'("remu");
          default: ;
        endcase
      end
      OPC_OP32: begin
        f = FMT_R;
        case ({f7, f3})
          {F7_BASE, F3_ADD}:    nm = OP_W'("addw");
          {F7_ALT,  F3_ADD}:    nm = OP_W'("subw");
          {F7_BASE, F3_SLL}:    nm = OP_W'("sllw");
          {F7_BASE, F3_SR}:     nm = OP_W'("srlw");
          {F7_ALT,  F3_SR}:     nm = OP_W'("sraw");
          {F7_MULDIV, F3_MUL}:  nm = OP_W'("mulw");
          {F7_MULDIV, F3_DIV}:  nm = OP_W'("divw");
          {F7_MULDIV, F3_DIVU}: nm = OP_W'("divuw");
          {F7_MULDIV, F3_REM}:  nm = OP_W'("remw");
          {F7_MULDIV, F3_REMU}: nm = OP_W'("remuw");
          default: ;
        endcase
      end
      OPC_MISC_MEM: begin f = FMT_SYS; if (f3 == 3'd0) nm = OP_W'("fence"); end
      OPC_SYSTEM: begin
        f = FMT_SYS;
        if (inst == 32'h0000_0073)      nm = OP_W'("ecall");
        else if (inst == 32'h0010_0073) nm = OP_W'("ebreak");
      end
      default: ;
    endcase
    if (nm == '0) begin
      d.fmt  = FMT_NONE;
      d.name = OP_W'("unknown");
    end else begin
      d.fmt  = f;
      d.name = nm;
    end
    return d;
  endfunction

  logic [31:0] inst;
  dec_t        dec;

  assign inst = stage1_instruction_bits;
  assign dec  = decode_inst(inst);

  // Immediate assembly by format; R-type and undefined encodings give zero
  always_comb begin
    nstage2_immediate = '0;
    case (dec.fmt)
      FMT_I, FMT_SYS: nstage2_immediate = BUS_DATA_WIDTH'($signed(inst[31:20]));
      FMT_S:   nstage2_immediate = BUS_DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
      FMT_B:   nstage2_immediate = BUS_DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25],
                                                            inst[11:8], 1'b0}));
      FMT_U:   nstage2_immediate = BUS_DATA_WIDTH'($signed({inst[31:12], 12'b0}));
      FMT_J:   nstage2_immediate = BUS_DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20],
                                                            inst[30:21], 1'b0}));
      FMT_SH:  nstage2_immediate = BUS_DATA_WIDTH'(inst[25:20]);
      FMT_SHW: nstage2_immediate = BUS_DATA_WIDTH'(inst[24:20]);
      default: nstage2_immediate = '0;
    endcase
  end

  assign nstage2_op   = dec.name;
  assign nstage2_dest = fmt_has_rd(dec.fmt) ? REGISTER_WIDTH'(inst[11:7]) : '0;
  assign nstage2_pc   = stage1_pc;

  decode_regfile #(
    .DATA_W (BUS_DATA_WIDTH),
    .ADDR_W (REGISTER_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (REGISTER_WIDTH'(inst[19:15])),
    .rd_addr_b (REGISTER_WIDTH'(inst[24:20])),
    .rd_data_a (nstage2_valA),
    .rd_data_b (nstage2_valB),
    .wr_en     (wb_en),
    .wr_addr   (wb_dest),
    .wr_data   (wb_data)
  );

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for decode: a match/mask opcode table plus a
// shadow register array predict every output; directed cases cover the
// documented examples, bypass, x0 and reset behaviour.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] stage1_instruction_bits;
  logic [63:0] stage1_pc;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [63:0] wb_data;
  logic [63:0] nstage2_valA, nstage2_valB, nstage2_immediate, nstage2_pc;
  logic [4:0]  nstage2_dest;
  logic [96:0] nstage2_op;

  decode dut (
    .clk                     (clk),
    .reset                   (reset),
    .stage1_instruction_bits (stage1_instruction_bits),
    .stage1_pc               (stage1_pc),
    .wb_en                   (wb_en),
    .wb_dest                 (wb_dest),
    .wb_data                 (wb_data),
    .nstage2_valA            (nstage2_valA),
    .nstage2_valB            (nstage2_valB),
    .nstage2_immediate       (nstage2_immediate),
    .nstage2_pc              (nstage2_pc),
    .nstage2_dest            (nstage2_dest),
    .nstage2_op              (nstage2_op)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int txn_no = 0;

  // Reference state
  logic [63:0] ref_regs [32];
  logic [31:0] t_mask [$];
  logic [31:0] t_match [$];
  string       t_name [$];
  logic [7:0]  t_fmt [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic add_op(input logic [31:0] mask, input logic [31:0] match,
                        input string nm, input logic [7:0] f);
    t_mask.push_back(mask);
    t_match.push_back(match);
    t_name.push_back(nm);
    t_fmt.push_back(f);
  endtask

  function automatic logic [96:0] str2op(input string s);
    logic [96:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[88:0], s[i]};
    return v;
  endfunction

  // Format codes: U J I B S R, H = 6-bit shamt, W = 5-bit shamt,
  // F = I-immediate with no rd (fence/ecall/ebreak), X = undefined
  task automatic build_table();
    add_op(32'h7F, 32'h37, "lui", "U");
    add_op(32'h7F, 32'h17, "auipc", "U");
    add_op(32'h7F, 32'h6F, "jal", "J");
    add_op(32'h707F, 32'h67, "jalr", "I");
    add_op(32'h707F, 32'h0063, "beq", "B");
    add_op(32'h707F, 32'h1063, "bne", "B");
    add_op(32'h707F, 32'h4063, "blt", "B");
    add_op(32'h707F, 32'h5063, "bge", "B");
    add_op(32'h707F, 32'h6063, "bltu", "B");
    add_op(32'h707F, 32'h7063, "bgeu", "B");
    add_op(32'h707F, 32'h0003, "lb", "I");
    add_op(32'h707F, 32'h1003, "lh", "I");
    add_op(32'h707F, 32'h2003, "lw", "I");
    add_op(32'h707F, 32'h3003, "ld", "I");
    add_op(32'h707F, 32'h4003, "lbu", "I");
    add_op(32'h707F, 32'h5003, "lhu", "I");
    add_op(32'h707F, 32'h6003, "lwu", "I");
    add_op(32'h707F, 32'h0023, "sb", "S");
    add_op(32'h707F, 32'h1023, "sh", "S");
    add_op(32'h707F, 32'h2023, "sw", "S");
    add_op(32'h707F, 32'h3023, "sd", "S");
    add_op(32'h707F, 32'h0013, "addi", "I");
    add_op(32'h707F, 32'h2013, "slti", "I");
    add_op(32'h707F, 32'h3013, "sltiu", "I");
    add_op(32'h707F, 32'h4013, "xori", "I");
    add_op(32'h707F, 32'h6013, "ori", "I");
    add_op(32'h707F, 32'h7013, "andi", "I");
    add_op(32'hFC00707F, 32'h1013, "slli", "H");
    add_op(32'hFC00707F, 32'h5013, "srli", "H");
    add_op(32'hFC00707F, 32'h40005013, "srai", "H");
    add_op(32'h707F, 32'h001B, "addiw", "I");
    add_op(32'hFE00707F, 32'h101B, "slliw", "W");
    add_op(32'hFE00707F, 32'h501B, "srliw", "W");
    add_op(32'hFE00707F, 32'h4000501B, "sraiw", "W");
    add_op(32'hFE00707F, 32'h0033, "add", "R");
    add_op(32'hFE00707F, 32'h40000033, "sub", "R");
    add_op(32'hFE00707F, 32'h1033, "sll", "R");
    add_op(32'hFE00707F, 32'h2033, "slt", "R");
    add_op(32'hFE00707F, 32'h3033, "sltu", "R");
    add_op(32'hFE00707F, 32'h4033, "xor", "R");
    add_op(32'hFE00707F, 32'h5033, "srl", "R");
    add_op(32'hFE00707F, 32'h40005033, "sra", "R");
    add_op(32'hFE00707F, 32'h6033, "or", "R");
    add_op(32'hFE00707F, 32'h7033, "and", "R");
    add_op(32'hFE00707F, 32'h02000033, "mul", "R");
    add_op(32'hFE00707F, 32'h02001033, "mulh", "R");
    add_op(32'hFE00707F, 32'h02002033, "mulhsu", "R");
    add_op(32'hFE00707F, 32'h02003033, "mulhu", "R");
    add_op(32'hFE00707F, 32'h02004033, "div", "R");
    add_op(32'hFE00707F, 32'h02005033, "divu", "R");
    add_op(32'hFE00707F, 32'h02006033, "rem", "R");
    add_op(32'hFE00707F, 32'h02007033, "remu", "R");
    add_op(32'hFE00707F, 32'h003B, "addw", "R");
    add_op(32'hFE00707F, 32'h4000003B, "subw", "R");
    add_op(32'hFE00707F, 32'h103B, "sllw", "R");
    add_op(32'hFE00707F, 32'h503B, "srlw", "R");
    add_op(32'hFE00707F, 32'h4000503B, "sraw", "R");
    add_op(32'hFE00707F, 32'h0200003B, "mulw", "R");
    add_op(32'hFE00707F, 32'h0200403B, "divw", "R");
    add_op(32'hFE00707F, 32'h0200503B, "divuw", "R");
    add_op(32'hFE00707F, 32'h0200603B, "remw", "R");
    add_op(32'hFE00707F, 32'h0200703B, "remuw", "R");
    add_op(32'h707F, 32'h000F, "fence", "F");
    add_op(32'hFFFFFFFF, 32'h00000073, "ecall", "F");
    add_op(32'hFFFFFFFF, 32'h00100073, "ebreak", "F");
  endtask

  // Reference decode: table lookup, then immediate/dest from the format rules
  task automatic model(input logic [31:0] inst, output string nm,
                       output logic [63:0] imm, output logic [4:0] dest);
    logic [7:0] f;
    nm = "unknown";
    f  = "X";
    foreach (t_mask[k])
      if ((inst & t_mask[k]) == t_match[k]) begin
        nm = t_name[k];
        f  = t_fmt[k];
      end
    case (f)
      "I", "F": imm = {{52{inst[31]}}, inst[31:20]};
      "S":      imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      "B":      imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      "U":      imm = {{32{inst[31]}}, inst[31:12], 12'h000};
      "J":      imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      "H":      imm = {58'd0, inst[25:20]};
      "W":      imm = {59'd0, inst[24:20]};
      default:  imm = 64'd0;
    endcase
    case (f)
      "S", "B", "F", "X": dest = 5'd0;
      default:            dest = inst[11:7];
    endcase
  endtask

  // One transaction: drive at negedge, check all outputs, then the write
  // lands in the shadow registers at the following posedge
  task automatic txn(input logic [31:0] inst, input logic [63:0] pc, input logic we,
                     input logic [4:0] wd, input logic [63:0] wdat);
    string       nm;
    logic [63:0] e_imm, e_a, e_b;
    logic [4:0]  e_dest, rs1, rs2;
    @(negedge clk);
    stage1_instruction_bits = inst;
    stage1_pc = pc;
    wb_en     = we;
    wb_dest   = wd;
    wb_data   = wdat;
    #1;
    model(inst, nm, e_imm, e_dest);
    rs1 = inst[19:15];
    rs2 = inst[24:20];
    e_a = (rs1 == 0) ? 64'd0 : (we && wd == rs1) ? wdat : ref_regs[rs1];
    e_b = (rs2 == 0) ? 64'd0 : (we && wd == rs2) ? wdat : ref_regs[rs2];
    check("op",   128'(nstage2_op), 128'(str2op(nm)));
    check("dest", 128'(nstage2_dest), 128'(e_dest));
    check("imm",  128'(nstage2_immediate), 128'(e_imm));
    check("pc",   128'(nstage2_pc), 128'(pc));
    check("valA", 128'(nstage2_valA), 128'(e_a));
    check("valB", 128'(nstage2_valB), 128'(e_b));
    $display("[TB] txn %0d inst=%08h op=%s dest=%0d imm=%h we=%0b wd=%0d",
             txn_no, inst, nm, e_dest, e_imm, we, wd);
    txn_no++;
    if (we && wd != 0) ref_regs[wd] = wdat;
  endtask

  initial begin
    logic [31:0] inst;
    logic [4:0]  wd;
    int          idx;

    foreach (ref_regs[i]) ref_regs[i] = 64'd0;
    build_table();
    reset = 1'b0;
    stage1_instruction_bits = 32'd0;
    stage1_pc = 64'd0;
    wb_en = 1'b0;
    wb_dest = 5'd0;
    wb_data = 64'd0;

    // Outputs are live during reset
    @(negedge clk);
    stage1_instruction_bits = 32'h00500093;
    stage1_pc = 64'h40;
    #1;
    check("rst_op",   128'(nstage2_op), 128'(str2op("addi")));
    check("rst_valA", 128'(nstage2_valA), 128'd0);
    @(negedge clk);
    reset = 1'b1;

    txn(32'h00500093, 64'h0000_0000_0000_1000, 1'b0, 5'd0, 64'd0);
    check("addi_op",   128'(nstage2_op), 128'(str2op("addi")));
    check("addi_dest", 128'(nstage2_dest), 128'd1);
    check("addi_imm",  128'(nstage2_immediate), 128'd5);
    check("addi_valA", 128'(nstage2_valA), 128'd0);
    check("addi_pc",   128'(nstage2_pc), 128'h1000);

    txn(32'h123452B7, 64'h1004, 1'b0, 5'd0, 64'd0);
    check("lui_op",   128'(nstage2_op), 128'(str2op("lui")));
    check("lui_dest", 128'(nstage2_dest), 128'd5);
    check("lui_imm",  128'(nstage2_immediate), 128'h0000_0000_1234_5000);

    txn(32'h0020A423, 64'h1008, 1'b0, 5'd0, 64'd0);
    check("sw_op",   128'(nstage2_op), 128'(str2op("sw")));
    check("sw_dest", 128'(nstage2_dest), 128'd0);
    check("sw_imm",  128'(nstage2_immediate), 128'd8);

    txn(32'hFE000EE3, 64'h100C, 1'b0, 5'd0, 64'd0);
    check("beq_op",   128'(nstage2_op), 128'(str2op("beq")));
    check("beq_imm",  128'(nstage2_immediate), 128'hFFFF_FFFF_FFFF_FFFC);
    check("beq_dest", 128'(nstage2_dest), 128'd0);

    // Write x3, then read it back through add x4,x3,x3
    txn(32'h00000013, 64'h1010, 1'b1, 5'd3, 64'hDEAD_BEEF);
    txn(32'h00318233, 64'h1014, 1'b0, 5'd0, 64'd0);
    check("add_op",   128'(nstage2_op), 128'(str2op("add")));
    check("add_dest", 128'(nstage2_dest), 128'd4);
    check("add_valA", 128'(nstage2_valA), 128'hDEAD_BEEF);
    check("add_valB", 128'(nstage2_valB), 128'hDEAD_BEEF);

    // x0 write ignored
    txn(32'h00000013, 64'h1018, 1'b1, 5'd0, 64'hFFFF_FFFF);
    txn(32'h00000033, 64'h101C, 1'b0, 5'd0, 64'd0);
    check("x0_valA", 128'(nstage2_valA), 128'd0);

    // Same-cycle write-through
    txn(32'h00318233, 64'h1020, 1'b1, 5'd3, 64'h1234);
    check("byp_valA", 128'(nstage2_valA), 128'h1234);

    // Randomized mix of table-derived and arbitrary words
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 85) begin
        idx  = $urandom_range(0, t_mask.size() - 1);
        inst = t_match[idx] | ($urandom & ~t_mask[idx]);
      end else begin
        inst = $urandom;
      end
      wd = ($urandom_range(0, 3) == 0) ? inst[19:15] : 5'($urandom);
      txn(inst, {$urandom, $urandom}, 1'($urandom), wd, {$urandom, $urandom});
    end

    // Reset asserted mid-operation with a write pending: write discarded
    @(negedge clk);
    stage1_instruction_bits = 32'h00318233;
    wb_en   = 1'b1;
    wb_dest = 5'd3;
    wb_data = 64'h5555;
    reset   = 1'b0;
    #1;
    check("rst2_valA", 128'(nstage2_valA), 128'd0);
    check("rst2_valB", 128'(nstage2_valB), 128'd0);
    foreach (ref_regs[i]) ref_regs[i] = 64'd0;
    @(negedge clk);
    wb_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rst2_disc", 128'(nstage2_valA), 128'd0);

    txn(32'h00000000, 64'h2000, 1'b0, 5'd0, 64'd0);
    check("unk_op",   128'(nstage2_op), 128'(str2op("unknown")));
    check("unk_dest", 128'(nstage2_dest), 128'd0);
    check("unk_imm",  128'(nstage2_immediate), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
